mure_block_unpacker: RTL
========================

Name: mure_block_unpacker

Overview:
- Consumer-side counterpart of the multiple-retirement block serializer.
- Accepts up to N trace blocks per cycle (iretire/ilastsize/itype/iaddr per lane, plus shared cause/tval/priv), buffers each cycle's group, and re-emits the blocks one per handshake on a single valid/ready port.
- Each emitted block carries the derived address of its last retired instruction.
- Used as the trace-side reference model in the MURE bench, and as the front end of single-lane trace consumers.

Parameters:
- N, 2, number of input block lanes per cycle (max special instructions per cycle).
- FIFO_DEPTH, 4, number of buffered input groups (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- valid_i  in  N  per-lane block valid.
- iretire_i  in  N x mure_pkg::IRETIRE_LEN  halfwords retired per lane.
- ilastsize_i  in  N  last instruction size per lane (0 = 2 bytes, 1 = 4 bytes).
- itype_i  in  N x mure_pkg::ITYPE_LEN  block type per lane.
- cause_i  in  mure_pkg::CAUSE_LEN  shared exception/interrupt cause.
- tval_i  in  mure_pkg::XLEN  shared trap value.
- priv_i  in  mure_pkg::PRIV_LEN  shared privilege level.
- iaddr_i  in  N x mure_pkg::XLEN  block start address per lane.
- valid_o  out  1  output block valid.
- ready_i  in  1  downstream accepts block.
- iretire_o  out  IRETIRE_LEN  block halfword count.
- ilastsize_o  out  1  last instruction size.
- itype_o  out  ITYPE_LEN  block type.
- cause_o  out  CAUSE_LEN  cause (itype 1/2 only, else 0).
- tval_o  out  XLEN  tval (itype 1/2 only, else 0).
- priv_o  out  PRIV_LEN  privilege level of the group.
- iaddr_o  out  XLEN  block start address.
- last_addr_o  out  XLEN  address of the last retired instruction in the block.
- last_o  out  1  current block is the final block of its group.
- overflow_o  out  1  sticky: a group was dropped because the FIFO was full.

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i): FIFO empty, lane index = 0, overflow_o = 0, every output = 0. Reset asserted mid-operation discards all buffered groups immediately.
- Group capture:
  - A cycle with |valid_i becomes one group.
  - Valid lanes are compacted in ascending lane order; invalid lanes are skipped.
  - count = popcount(valid_i), range 1..N, stored with the group.
  - shared cause/tval/priv are stored once per group.
- Push rule: push when |valid_i && !full. If |valid_i && full (after accounting for a same-cycle pop), the group is dropped and overflow_o is set; it stays at 1 until reset.
- Simultaneous push and pop are allowed in the same cycle. A full FIFO with a same-cycle pop accepts the push without overflow.
- Latency: a group pushed in cycle t presents its first block with valid_o = 1 in cycle t+1 (registered storage, no fall-through).
- Output state machine, IDLE / EMIT:
  - IDLE: FIFO empty, valid_o = 0. Move to EMIT when FIFO becomes non-empty.
  - EMIT: valid_o = 1, outputs show compacted lane[idx] of the head group.
  - On valid_o && ready_i:
    - if idx == count-1: pop the group, idx = 0; go to IDLE if the FIFO becomes empty, else stay in EMIT on the next group.
    - otherwise idx = idx+1.
- Output stability: when valid_o && !ready_i, every output holds stable.
- last_o = (idx == count-1).
- last_addr_o:
  - iretire == 0: last_addr_o = iaddr.
  - otherwise: iaddr + (iretire << 1) - (ilastsize ? 4 : 2).
  - Computed at XLEN width, wraps modulo 2^XLEN.
- cause_o/tval_o are driven from the group only when itype_o is 1 or 2, else 0.
- priv_o is the group priv for every block of the group.
- Index counter width is $clog2(N)+1. idx never exceeds count-1.

Test Plan:
- Single lane: N=2, valid_i=01, iaddr=0x1000, iretire=6, ilastsize=1, itype=3, ready_i=1 -> one cycle later: one beat, last_addr_o=0x1008, last_o=1, cause_o=0.
- Two lanes with backpressure: valid_i=11, lane0 iaddr=0x2000/iretire=2/ilastsize=0, lane1 iaddr=0x3000/iretire=4/ilastsize=1, ready_i low for 3 cycles -> lane0 block held stable for 3 cycles (last_addr 0x2002, last_o=0), then lane1 block (last_addr 0x3004, last_o=1).
- Sparse lanes: valid_i=10 -> single beat carrying lane1 data, last_o=1.
- Exception block: itype=1, cause=0x2, tval=0xDEAD, iretire=0, iaddr=0x4000 -> cause_o=0x2, tval_o=0xDEAD, last_addr_o=0x4000.
- Overflow: ready_i=0, push 5 groups with FIFO_DEPTH=4 -> 5th group dropped, overflow_o=1 and sticky. Then push with a same-cycle pop at full -> accepted.
- Wrap and reset: iaddr=0xFFFF_FFFE (XLEN=32), iretire=3, ilastsize=1 -> last_addr_o=0x0000_0000. Assert reset during EMIT -> valid_o=0 and overflow_o=0 in the same cycle.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared widths and block bundle for the MURE trace path.
// Blocks carry halfword count, last size, type and start address.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 7;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } blk_t;

endpackage

// File: rtl/mure_block_unpacker_if.sv
// Bus bundle of the block unpacker: N-lane group input side
// and single-lane valid/ready block output side.
interface mure_block_unpacker_if #(
  parameter int N = 2
);

  logic [N-1:0]                             valid_i;
  logic [N-1:0][mure_pkg::IRETIRE_LEN-1:0]  iretire_i;
  logic [N-1:0]                             ilastsize_i;
  logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]    itype_i;
  logic [mure_pkg::CAUSE_LEN-1:0]           cause_i;
  logic [mure_pkg::XLEN-1:0]                tval_i;
  logic [mure_pkg::PRIV_LEN-1:0]            priv_i;
  logic [N-1:0][mure_pkg::XLEN-1:0]         iaddr_i;

  logic                                     valid_o;
  logic                                     ready_i;
  logic [mure_pkg::IRETIRE_LEN-1:0]         iretire_o;
  logic                                     ilastsize_o;
  logic [mure_pkg::ITYPE_LEN-1:0]           itype_o;
  logic [mure_pkg::CAUSE_LEN-1:0]           cause_o;
  logic [mure_pkg::XLEN-1:0]                tval_o;
  logic [mure_pkg::PRIV_LEN-1:0]            priv_o;
  logic [mure_pkg::XLEN-1:0]                iaddr_o;
  logic [mure_pkg::XLEN-1:0]                last_addr_o;
  logic                                     last_o;
  logic                                     overflow_o;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i,
    output cause_i, tval_i, priv_i, iaddr_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o,
    input  cause_o, tval_o, priv_o, iaddr_o,
    input  last_addr_o, last_o, overflow_o
  );

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i,
    input  cause_i, tval_i, priv_i, iaddr_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o,
    output cause_o, tval_o, priv_o, iaddr_o,
    output last_addr_o, last_o, overflow_o
  );

endinterface

// File: rtl/mure_block_unpacker.sv
// Buffers N-lane trace block groups in a small FIFO and
// re-emits them one block per valid/ready handshake.
module mure_block_unpacker
  import mure_pkg::*;
#(
  parameter int N          = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  mure_block_unpacker_if.slave bus
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    blk_t [N-1:0]         blk;
    logic [CW-1:0]        cnt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } grp_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  grp_t          mem [FIFO_DEPTH];
  grp_t          grp_in, head;
  blk_t          cur;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   used_q, used_d;
  logic [CW-1:0] idx_q, idx_d, pos;
  logic          ovf_q, any_v, full, emit;
  logic          fire, pop, push, trap;

  assign any_v = |bus.valid_i;
  assign full  = (used_q == FULL_C);
  assign emit  = (state_q == EMIT);
  assign head  = mem[rptr_q];
  assign cur   = head.blk[idx_q[IW-1:0]];
  assign fire  = emit && bus.ready_i;
  assign pop   = fire && (idx_q == head.cnt - 1'b1);
  assign push  = any_v && (!full || pop);
  assign used_d = used_q + (AW+1)'(push)
                - (AW+1)'(pop);

  // Compact valid lanes into the low slots of a new group.
  always_comb begin
    grp_in       = '0;
    pos          = '0;
    grp_in.cause = bus.cause_i;
    grp_in.tval  = bus.tval_i;
    grp_in.priv  = bus.priv_i;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (bus.valid_i[i] && pos == CW'(k)) begin
          grp_in.blk[k] = '{
            iretire:   bus.iretire_i[i],
            ilastsize: bus.ilastsize_i[i],
            itype:     bus.itype_i[i],
            iaddr:     bus.iaddr_i[i]
          };
        end
      end
      pos = pos + CW'(bus.valid_i[i]);
    end
    grp_in.cnt = pos;
  end

  // Next state and lane index of the output walker.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = EMIT;
      end
      EMIT: begin
        if (pop) begin
          idx_d = '0;
          if (used_d == '0) state_d = IDLE;
        end else if (fire) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy, walker state, sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      used_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      used_q  <= used_d;
      if (any_v && !push) ovf_q <= 1'b1;
    end
  end

  // Group storage; contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= grp_in;
  end

  assign trap = (cur.itype == ITYPE_LEN'(1))
             || (cur.itype == ITYPE_LEN'(2));

  // Present the current block, forced to zero while idle.
  always_comb begin
    bus.valid_o     = emit;
    bus.iretire_o   = '0;
    bus.ilastsize_o = 1'b0;
    bus.itype_o     = '0;
    bus.cause_o     = '0;
    bus.tval_o      = '0;
    bus.priv_o      = '0;
    bus.iaddr_o     = '0;
    bus.last_addr_o = '0;
    bus.last_o      = 1'b0;
    if (emit) begin
      bus.iretire_o   = cur.iretire;
      bus.ilastsize_o = cur.ilastsize;
      bus.itype_o     = cur.itype;
      bus.priv_o      = head.priv;
      bus.iaddr_o     = cur.iaddr;
      bus.last_o      = (idx_q == head.cnt - 1'b1);
      bus.last_addr_o = cur.iaddr;
      if (cur.iretire != '0) begin
        bus.last_addr_o = cur.iaddr
          + (XLEN'(cur.iretire) << 1)
          - (cur.ilastsize ? XLEN'(4) : XLEN'(2));
      end
      if (trap) begin
        bus.cause_o = head.cause;
        bus.tval_o  = head.tval;
      end
    end
  end

  assign bus.overflow_o = ovf_q;

endmodule
